// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio event scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package audio_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HALT = 2'd2
  } sched_state_t;

  // Key driven on sound_key while nothing is playing.
  localparam int SILENT_KEY_DEF = 15;

  // Channel i is presented to the tone generator as key i+1, so key 0 is never a real sound.
  function automatic logic [7:0] key_of(input logic [2:0] idx);
    return {5'd0, idx} + 8'd1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: idx = lowest asserted request index, vld = any request.
// Latency: purely combinational.
// Backpressure: not applicable.
//   req : request vector, bit 0 has the highest priority
//   idx : index of the lowest set bit (0 when vld is low)
//   vld : at least one bit of req is set
module prio_enc #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/audio_event_sched.sv
// Sound-event scheduler: queues request pulses as pending bits and plays one channel at a time for its tick duration.
// Latency: 1 clk from request (in IDLE) to sound_key; back-to-back hand-over has no silent cycle.
// Backpressure: none; requests that cannot play now are held as sticky pending bits (repeats coalesce).
//   clk, resetN      : clock and asynchronous active-low reset
//   slowClk          : one-clk-wide duration tick enable
//   event_req        : one-cycle request pulses, channel 0 highest priority
//   dur_table        : per-channel duration in ticks, channel i at [i*DUR_W +: DUR_W]
//   sound_key        : i+1 while channel i plays, else SILENT_KEY
//   playing/halted   : state flags; cur_evt = playing channel (0 when not playing)
//   start_pulse      : one clk whenever a sound starts or restarts
module audio_event_sched
  import audio_pkg::*;
#(
  parameter int NUM_EVENTS   = 4,
  parameter int DUR_W        = 4,
  parameter int KEY_W        = 4,
  parameter int SILENT_KEY   = SILENT_KEY_DEF,
  parameter int TERMINAL_EVT = 1,
  parameter int PREEMPT      = 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        slowClk,
  input  logic [NUM_EVENTS-1:0]       event_req,
  input  logic [NUM_EVENTS*DUR_W-1:0] dur_table,
  output logic [KEY_W-1:0]            sound_key,
  output logic                        playing,
  output logic [2:0]                  cur_evt,
  output logic                        halted,
  output logic                        start_pulse
);

  localparam logic [2:0]            TERM_IDX = 3'(TERMINAL_EVT);
  localparam logic [NUM_EVENTS-1:0] TERM_BIT = NUM_EVENTS'(1) << TERMINAL_EVT;

  sched_state_t          state_q, state_d;
  logic [NUM_EVENTS-1:0] pending_q, pending_d;
  logic [DUR_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            cur_q, cur_d;
  logic                  start_d;

  logic [KEY_W-1:0]      sound_key_q, sound_key_d;
  logic                  playing_q, playing_d;
  logic [2:0]            cur_evt_q, cur_evt_d;
  logic                  halted_q, halted_d;
  logic                  start_pulse_q;

  logic [NUM_EVENTS-1:0] req_all;
  logic [2:0]            sel;
  logic                  sel_vld;
  logic [NUM_EVENTS-1:0] sel_bit;
  logic [NUM_EVENTS-1:0] cur_bit;
  logic                  done;
  logic                  cur_is_term;
  logic [7:0]            key_full;

  // A zero duration would otherwise never complete; it plays as one tick.
  function automatic logic [DUR_W-1:0] dur_of(input logic [NUM_EVENTS*DUR_W-1:0] tbl,
                                               input logic [2:0] idx);
    logic [DUR_W-1:0] d;
    d = tbl[idx*DUR_W +: DUR_W];
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  assign req_all = pending_q | event_req;

  prio_enc #(.N(NUM_EVENTS), .IW(3)) u_prio_enc (
    .req (req_all),
    .idx (sel),
    .vld (sel_vld)
  );

  assign sel_bit     = NUM_EVENTS'(1) << sel;
  assign cur_bit     = NUM_EVENTS'(1) << cur_q;
  assign done        = slowClk && (cnt_q == DUR_W'(1));
  assign cur_is_term = (cur_q == TERM_IDX);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    start_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d   = PLAY;
          cur_d     = sel;
          cnt_d     = dur_of(dur_table, sel);
          pending_d = req_all & ~sel_bit;
          start_d   = 1'b1;
        end
      end

      PLAY: begin
        if (event_req[TERMINAL_EVT]) begin
          // Terminal request wins over everything; the aborted sound is dropped.
          cur_d     = TERM_IDX;
          cnt_d     = dur_of(dur_table, TERM_IDX);
          pending_d = pending_q | (event_req & ~TERM_BIT & ~cur_bit);
          start_d   = 1'b1;
        end else if ((PREEMPT != 0) && sel_vld && (sel < cur_q) && !cur_is_term) begin
          // Once the terminal sound runs, lower-index pending bits must never be serviced.
          cur_d     = sel;
          cnt_d     = dur_of(dur_table, sel);
          pending_d = req_all & ~sel_bit & ~cur_bit;
          start_d   = 1'b1;
        end else if ((event_req & cur_bit) != '0) begin
          // Retrigger of the playing channel: restart its duration, never queue it.
          cnt_d     = dur_of(dur_table, cur_q);
          pending_d = pending_q | (event_req & ~cur_bit);
          start_d   = 1'b1;
        end else if (done) begin
          if (cur_is_term) begin
            state_d   = HALT;
            cnt_d     = '0;
            pending_d = pending_q | event_req;
          end else if (sel_vld) begin
            cur_d     = sel;
            cnt_d     = dur_of(dur_table, sel);
            pending_d = req_all & ~sel_bit;
            start_d   = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          pending_d = pending_q | event_req;
          if (slowClk && (cnt_q > DUR_W'(1))) cnt_d = cnt_q - DUR_W'(1);
        end
      end

      HALT: begin
        // Absorbing: only resetN leaves this state.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they change together with the state.
  always_comb begin
    key_full    = key_of(cur_d);
    playing_d   = (state_d == PLAY);
    halted_d    = (state_d == HALT);
    cur_evt_d   = playing_d ? cur_d : 3'd0;
    sound_key_d = playing_d ? key_full[KEY_W-1:0] : KEY_W'(SILENT_KEY);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      cnt_q         <= '0;
      cur_q         <= 3'd0;
      sound_key_q   <= KEY_W'(SILENT_KEY);
      playing_q     <= 1'b0;
      cur_evt_q     <= 3'd0;
      halted_q      <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      cur_q         <= cur_d;
      sound_key_q   <= sound_key_d;
      playing_q     <= playing_d;
      cur_evt_q     <= cur_evt_d;
      halted_q      <= halted_d;
      start_pulse_q <= start_d;
    end
  end

  assign sound_key   = sound_key_q;
  assign playing     = playing_q;
  assign cur_evt     = cur_evt_q;
  assign halted      = halted_q;
  assign start_pulse = start_pulse_q;

endmodule
